// File: rtl/fft_reorder_if.sv
// Sample stream bundle around the FFT output reorder buffer: bit-reversed samples
// in, natural-order samples out, plus the sticky resync flag.
interface fft_reorder_if #(
  parameter int data_width = 14
);
  logic [data_width-1:0] in_r;
  logic [data_width-1:0] in_i;
  logic                  in_valid;
  logic                  in_first;
  logic [data_width-1:0] out_r;
  logic [data_width-1:0] out_i;
  logic                  out_valid;
  logic                  out_first;
  logic                  out_last;
  logic                  frame_err;

  modport master (
    output in_r, in_i, in_valid, in_first,
    input  out_r, out_i, out_valid, out_first, out_last, frame_err
  );

  modport slave (
    input  in_r, in_i, in_valid, in_first,
    output out_r, out_i, out_valid, out_first, out_last, frame_err
  );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order from the last
// butterfly stage and leave in natural frequency order, gapless under full rate.
module fft_reorder #(
  parameter int data_width = 14,
  parameter int log2_n     = 6
) (
  input  logic         clock,
  input  logic         reset,
  fft_reorder_if.slave bus
);

  localparam int n = 2 ** log2_n;

  typedef logic [log2_n-1:0]       addr_t;
  typedef logic [2*data_width-1:0] word_t;

  localparam addr_t last_addr = addr_t'(n - 1);

  function automatic addr_t bitrev(input addr_t a);
    addr_t r;
    for (int b = 0; b < log2_n; b++) begin
      r[b] = a[log2_n-1-b];
    end
    return r;
  endfunction

  // Both banks share one array; the MSB of the index is the bank select.
  word_t mem_q [2*n];

  addr_t wr_cnt_q, wr_cnt_d;
  logic  wr_bank_q, wr_bank_d;
  logic [1:0] full_q, full_d;
  logic  frame_err_q, frame_err_d;
  addr_t rd_cnt_q, rd_cnt_d;
  logic  rd_bank_q, rd_bank_d;

  logic [data_width-1:0] out_r_q, out_r_d;
  logic [data_width-1:0] out_i_q, out_i_d;
  logic out_valid_q, out_valid_d;
  logic out_first_q, out_first_d;
  logic out_last_q, out_last_d;

  logic  resync_s;
  logic  wr_last_s;
  addr_t wr_addr_s;
  logic  rd_en_s;
  addr_t rd_addr_s;
  word_t rd_data_s;

  assign resync_s  = bus.in_valid && bus.in_first && (wr_cnt_q != {log2_n{1'b0}});
  assign wr_last_s = bus.in_valid && !resync_s && (wr_cnt_q == last_addr);
  assign wr_addr_s = resync_s ? {log2_n{1'b0}} : wr_cnt_q;
  // Banks drain in the same order they fill, so the reader only watches its own bank.
  assign rd_en_s   = full_q[rd_bank_q];
  assign rd_addr_s = bitrev(rd_cnt_q);
  assign rd_data_s = mem_q[{rd_bank_q, rd_addr_s}];

  // Sample storage; contents are never reset.
  always_ff @(posedge clock) begin
    if (bus.in_valid) begin
      mem_q[{wr_bank_q, wr_addr_s}] <= {bus.in_r, bus.in_i};
    end
  end

  // Next-state for write/read counters, bank flags and output stage.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    full_d      = full_q;
    frame_err_d = frame_err_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;

    if (resync_s) begin
      wr_cnt_d    = addr_t'(1);
      frame_err_d = 1'b1;
    end else if (wr_last_s) begin
      wr_cnt_d  = {log2_n{1'b0}};
      wr_bank_d = ~wr_bank_q;
    end else if (bus.in_valid) begin
      wr_cnt_d = wr_cnt_q + addr_t'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (rd_en_s && (rd_cnt_q == last_addr)) begin
      rd_cnt_d          = {log2_n{1'b0}};
      rd_bank_d         = ~rd_bank_q;
      full_d[rd_bank_q] = 1'b0;
    end else if (rd_en_s) begin
      rd_cnt_d = rd_cnt_q + addr_t'(1);
    end else begin
      rd_cnt_d = rd_cnt_q;
    end

    // The bank being filled is never the one being drained, so set and clear never collide.
    full_d = full_d | ({1'b0, wr_last_s} << wr_bank_q);

    out_valid_d = rd_en_s;
    out_r_d     = rd_en_s ? rd_data_s[2*data_width-1 -: data_width] : {data_width{1'b0}};
    out_i_d     = rd_en_s ? rd_data_s[data_width-1:0] : {data_width{1'b0}};
    out_first_d = rd_en_s && (rd_cnt_q == {log2_n{1'b0}});
    out_last_d  = rd_en_s && (rd_cnt_q == last_addr);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_q    <= {log2_n{1'b0}};
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      frame_err_q <= 1'b0;
      rd_cnt_q    <= {log2_n{1'b0}};
      rd_bank_q   <= 1'b0;
      out_r_q     <= {data_width{1'b0}};
      out_i_q     <= {data_width{1'b0}};
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder (N=8): a frame-level model schedules expected outputs per
// cycle; directed scenarios add hand-computed literal checks.
module tb_fft_reorder;
  localparam int W  = 14;
  localparam int LN = 3;
  localparam int N  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fft_reorder_if #(.data_width(W)) bus ();

  fft_reorder #(.data_width(W), .log2_n(LN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic         first;
    logic         last;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   cyc       = 0;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   fcnt      = 0;
  int   next_free = 0;
  int   last_wr_p = 0;
  bit   armed     = 1'b0;
  logic m_err     = 1'b0;
  logic [W-1:0] fr_r [N];
  logic [W-1:0] fr_i [N];
  int   lit [8]   = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int rev3(input int k);
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
  endfunction

  function automatic int neg14(input int k);
    return (16384 - k) % 16384;
  endfunction

  function automatic int obs_r(input int j);
    return (j < obs_q.size()) ? int'(obs_q[j].r) : -1;
  endfunction
  function automatic int obs_i(input int j);
    return (j < obs_q.size()) ? int'(obs_q[j].i) : -1;
  endfunction
  function automatic int obs_c(input int j);
    return (j < obs_q.size()) ? obs_q[j].cyc : -1;
  endfunction
  function automatic int obs_f(input int j);
    return (j < obs_q.size()) ? int'(obs_q[j].first) : -1;
  endfunction
  function automatic int obs_l(input int j);
    return (j < obs_q.size()) ? int'(obs_q[j].last) : -1;
  endfunction

  // Frame model: collect a whole frame, then schedule its bins in natural order.
  initial forever begin
    ent_t e;
    int   start;
    @(posedge clock);
    cyc++;
    if (reset) begin
      exp_q.delete();
      fcnt      = 0;
      m_err     = 1'b0;
      next_free = 0;
      armed     = 1'b1;
    end else if (bus.in_valid) begin
      if (bus.in_first && fcnt != 0) begin
        m_err = 1'b1;
        fcnt  = 0;
      end
      fr_r[fcnt] = bus.in_r;
      fr_i[fcnt] = bus.in_i;
      fcnt++;
      if (fcnt == N) begin
        start = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        for (int k = 0; k < N; k++) begin
          e.cyc   = start + k;
          e.r     = fr_r[rev3(k)];
          e.i     = fr_i[rev3(k)];
          e.first = (k == 0);
          e.last  = (k == N - 1);
          exp_q.push_back(e);
        end
        next_free = start + N;
        fcnt      = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clock);
    if (armed) begin
      int   p;
      ent_t o;
      logic ev;
      logic [W-1:0] er, ei;
      logic ef, el;
      p  = cyc + 1;
      ev = 1'b0; er = '0; ei = '0; ef = 1'b0; el = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == p) begin
        ev = 1'b1;
        er = exp_q[0].r;
        ei = exp_q[0].i;
        ef = exp_q[0].first;
        el = exp_q[0].last;
        void'(exp_q.pop_front());
      end
      n_vec++;
      if (bus.out_valid !== ev || bus.out_r !== er || bus.out_i !== ei ||
          bus.out_first !== ef || bus.out_last !== el || bus.frame_err !== m_err) begin
        n_err++;
        $display("FAIL cycle_cmp p=%0d got v=%b f=%b l=%b r=%h i=%h err=%b want v=%b f=%b l=%b r=%h i=%h err=%b",
                 p, bus.out_valid, bus.out_first, bus.out_last, bus.out_r, bus.out_i, bus.frame_err,
                 ev, ef, el, er, ei, m_err);
      end
      if (bus.out_valid === 1'b1) begin
        o.cyc = p; o.r = bus.out_r; o.i = bus.out_i; o.first = bus.out_first; o.last = bus.out_last;
        obs_q.push_back(o);
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [W-1:0] r, input logic [W-1:0] i);
    @(negedge clock);
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_r     = r;
    bus.in_i     = i;
    if (v) last_wr_p = cyc + 1;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_r     = '0;
    bus.in_i     = '0;
    reset        = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_err", int'(bus.frame_err), 0);
    check("rst_out_r", int'(bus.out_r), 0);

    // single frame, r=k, i=-k
    obs_q.delete();
    for (int k = 0; k < N; k++) drive(1'b1, k == 0, W'(k), W'(neg14(k)));
    idle(12);
    check("t1_count", obs_q.size(), 8);
    for (int j = 0; j < N; j++) begin
      check("t1_r", obs_r(j), lit[j]);
      check("t1_i", obs_i(j), neg14(lit[j]));
    end
    check("t1_first_cyc", obs_c(0), last_wr_p + 2);
    check("t1_last_cyc", obs_c(7), last_wr_p + 9);
    check("t1_first_flag", obs_f(0), 1);
    check("t1_last_flag", obs_l(7), 1);

    // three back-to-back frames
    obs_q.delete();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, W'(16 * f + k), W'(100 + 16 * f + k));
    idle(14);
    check("t2_count", obs_q.size(), 24);
    check("t2_span", obs_c(23) - obs_c(0), 23);
    check("t2_last_cyc", obs_c(23), last_wr_p + 9);
    check("t2_f1_bin1", obs_r(9), 20);
    check("t2_f2_bin0", obs_r(16), 32);
    check("t2_f1_first", obs_f(8), 1);
    check("t2_f1_last", obs_l(15), 1);
    check("t2_f2_i_bin3", obs_i(19), 100 + 32 + 6);

    // in_valid toggling
    obs_q.delete();
    for (int k = 0; k < N; k++) begin
      drive(1'b1, k == 0, W'(k), W'(neg14(k)));
      drive(1'b0, 1'b0, '0, '0);
    end
    idle(12);
    check("t3_count", obs_q.size(), 8);
    check("t3_first_cyc", obs_c(0), last_wr_p + 2);
    check("t3_bin1", obs_r(1), 4);
    check("t3_bin2", obs_r(2), 2);
    check("t3_bin7_i", obs_i(7), neg14(7));

    // extreme values
    obs_q.delete();
    for (int k = 0; k < N; k++)
      drive(1'b1, k == 0, (k == 1) ? 14'h2000 : (k == 6) ? 14'h1FFF : W'(k),
            (k == 1) ? 14'h1FFF : (k == 6) ? 14'h2000 : 14'h0000);
    idle(12);
    check("t6_bin4_r", obs_r(4), 32'h2000);
    check("t6_bin4_i", obs_i(4), 32'h1FFF);
    check("t6_bin3_r", obs_r(3), 32'h1FFF);
    check("t6_bin3_i", obs_i(3), 32'h2000);

    // resync after 5 samples
    obs_q.delete();
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, W'(50 + k), '0);
    for (int k = 0; k < N; k++) drive(1'b1, k == 0, W'(k), W'(neg14(k)));
    idle(12);
    check("t4_err", int'(bus.frame_err), 1);
    check("t4_count", obs_q.size(), 8);
    check("t4_first_cyc", obs_c(0), last_wr_p + 2);
    check("t4_bin0", obs_r(0), 0);
    check("t4_bin1", obs_r(1), 4);
    check("t4_bin7", obs_r(7), 7);
    idle(3);
    check("t4_err_sticky", int'(bus.frame_err), 1);

    // reset while frame A drains and frame B is half written
    obs_q.delete();
    for (int k = 0; k < N; k++) drive(1'b1, k == 0, W'(200 + k), '0);
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, W'(300 + k), '0);
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("t5_valid_after_rst", int'(bus.out_valid), 0);
    check("t5_r_after_rst", int'(bus.out_r), 0);
    idle(2);
    check("t5_err_clr", int'(bus.frame_err), 0);
    check("t5_partial", obs_q.size(), 4);
    check("t5_a_bin3", obs_r(3), 206);
    for (int k = 0; k < N; k++) drive(1'b1, k == 0, W'(400 + k), W'(k));
    idle(12);
    check("t5_count", obs_q.size(), 12);
    check("t5_c_first_cyc", obs_c(4), last_wr_p + 2);
    check("t5_c_bin0", obs_r(4), 400);
    check("t5_c_bin1", obs_r(5), 404);
    check("t5_c_bin7_i", obs_i(11), 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
